traffic_conflict_monitor: RTL
=============================

// Module: traffic_conflict_monitor
// PURPOSE
//  Safety monitor on the signal-head side of the 4-road traffic light controller.
//  It samples traffic1..traffic4 every clock, tracks each road's colour sequence and
//  dwell time, and latches the first safety violation: bad encoding, conflicting
//  greens, an illegal colour step, a short yellow or a green overrun.
//  fault drives the cabinet's all-red flash override. Only clr_fault clears it.
// PARAMETERS
//  MIN_YELLOW  5   minimum legal yellow dwell, in cycles (matches controller Shift)
//  MAX_GREEN   0   maximum continuous green dwell, in cycles; 0 disables the check
//  CNT_W       6   dwell counter width; MIN_YELLOW and MAX_GREEN must be < 2**CNT_W
//  PC_W        16  width of the phase_count counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  traffic1..4  in   3 ea.  one-hot light code: Green=3'b001, Yellow=3'b010, Red=3'b100
//  clr_fault    in   1      one-cycle pulse that clears the latched fault
//  fault        out  1      latched violation flag (all-red override request)
//  fault_code   out  3      0 none, 1 bad encoding, 2 conflict, 3 illegal step, 4 short yellow, 5 green overrun
//  fault_road   out  4      one-hot mask of the roads involved (bit0 = road1)
//  active_road  out  4      registered mask of roads whose sampled colour is not Red
//  phase_count  out  PC_W   count of completed Yellow->Red steps (all roads), wraps
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - prev_col[r] = Red, dwell[r] = 0
//   - fault = 0, fault_code = 0, fault_road = 0, active_road = 0, phase_count = 0
//  Per road r, each edge:
//   - cur = trafficN
//   - If cur is valid and cur != prev_col[r]: prev_col <= cur, dwell <= 1.
//   - If cur is valid and cur == prev_col[r]: dwell <= dwell+1, saturating at 2**CNT_W-1.
//   - If cur is invalid (not one-hot, or 000): prev_col and dwell hold, and no other check runs for r.
//  Checks (combinational on cur vs prev_col, dwell; results registered at the same edge):
//   - 1 bad encoding: any cur not in {001,010,100}.
//   - 2 conflict: more than one valid cur is non-Red. fault_road = all non-Red roads.
//   - 3 illegal step: allowed steps are R->G, G->Y, Y->R and hold. Illegal steps are
//     G->R, R->Y and Y->G.
//   - 4 short yellow: Y->R while dwell < MIN_YELLOW.
//   - 5 overrun: MAX_GREEN != 0, cur = G = prev, and dwell >= MAX_GREEN.
//  Fault latching:
//   - Latency is 1 cycle: fault is high in the cycle after the offending sample.
//   - Same-cycle priority: 1 > 2 > 3 > 4 > 5. For the winning code, fault_road is
//     the OR of every road with that code.
//   - The first fault is sticky. While fault=1, new violations are ignored;
//     monitoring (prev_col, dwell, phase_count) continues.
//   - clr_fault with no violation that cycle: fault, code and road go to 0 next cycle.
//   - clr_fault with a violation in the same cycle: the new violation is latched
//     (clear loses).
//  active_road[r] <= (cur valid && cur != Red). For an invalid cur it is 0.
//  phase_count increments by 1 per legal Y->R step. It adds 2 if two roads step at
//  once, which already implies a conflict. It wraps at 2**PC_W.
//  rst mid-operation: all state returns to reset values. The first sample after rst
//  is judged against prev = Red, so a green there is legal.
//  No other FSM exists. The per-road colour register acts as a 3-state FSM
//  (R/G/Y) with the transitions above.
// TESTING
//  T1 legal cycle: road1 R->G(10 cyc)->Y(5)->R, then road2 the same
//     -> fault stays 0; phase_count = 2; active_road = 0001 then 0010.
//  T2 conflict: traffic1 = G and traffic3 = G in the same cycle
//     -> next cycle fault = 1, fault_code = 2, fault_road = 0101.
//  T3 short yellow: road2 G->Y(3 cyc)->R with MIN_YELLOW = 5
//     -> fault_code = 4, fault_road = 0010; phase_count unchanged.
//  T4 illegal step plus bad encoding in one cycle: road1 G->R while traffic4 = 011
//     -> fault_code = 1, fault_road = 1000 (priority).
//     Then pulse clr_fault -> fault = 0 in the next cycle.
//  T5 sticky and clear race: latch code 3, inject code 2 (ignored), then
//     clr_fault together with a Y->G on road3 -> fault_code = 3, fault_road = 0100.
//  T6 overrun and reset: MAX_GREEN = 20, road4 green for 25 cycles
//     -> code 5 after 20 cycles. Assert rst mid-phase -> all outputs 0 next cycle.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: latches the first safety violation seen on four traffic signal heads
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 5,
  parameter int MAX_GREEN  = 0,
  parameter int CNT_W      = 6,
  parameter int PC_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      traffic1,
  input  logic [2:0]      traffic2,
  input  logic [2:0]      traffic3,
  input  logic [2:0]      traffic4,
  input  logic            clr_fault,
  output logic            fault,
  output logic [2:0]      fault_code,
  output logic [3:0]      fault_road,
  output logic [3:0]      active_road,
  output logic [PC_W-1:0] phase_count
);
  typedef enum logic [2:0] {GREEN = 3'b001, YELLOW = 3'b010, RED = 3'b100} col_e;
  localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GREEN);
  col_e             prev_col_q [4];
  col_e             prev_col_d [4];
  logic [CNT_W-1:0] dwell_q    [4];
  logic [CNT_W-1:0] dwell_d    [4];
  logic [2:0]       cur        [4];
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic [3:0]       fault_road_q, fault_road_d;
  logic [3:0]       active_road_q, active_road_d;
  logic [PC_W-1:0]  phase_count_q, phase_count_d;
  logic [3:0]       valid, bad, nonred, conflict, illegal, short_y, overrun, step_yr;
  logic [2:0]       win_code;
  logic [3:0]       win_road;
  logic             latch;
  assign cur[0] = traffic1;
  assign cur[1] = traffic2;
  assign cur[2] = traffic3;
  assign cur[3] = traffic4;
  // per-road colour tracking, violation detection and sticky fault arbitration
  always_comb begin
    phase_count_d = phase_count_q;
    for (int r = 0; r < 4; r++) begin
      valid[r]      = cur[r] == GREEN || cur[r] == YELLOW || cur[r] == RED;
      bad[r]        = !valid[r];
      nonred[r]     = valid[r] && cur[r] != RED;
      illegal[r]    = valid[r] && ((prev_col_q[r] == GREEN && cur[r] == RED) ||
                      (prev_col_q[r] == RED && cur[r] == YELLOW) || (prev_col_q[r] == YELLOW && cur[r] == GREEN));
      step_yr[r]    = valid[r] && prev_col_q[r] == YELLOW && cur[r] == RED;
      short_y[r]    = step_yr[r] && dwell_q[r] < MIN_Y;
      overrun[r]    = MAX_GREEN != 0 && valid[r] && cur[r] == GREEN && prev_col_q[r] == GREEN && dwell_q[r] >= MAX_G;
      prev_col_d[r] = valid[r] ? col_e'(cur[r]) : prev_col_q[r];
      dwell_d[r]    = !valid[r] ? dwell_q[r] : cur[r] != prev_col_q[r] ? CNT_W'(1) :
                      dwell_q[r] == '1 ? dwell_q[r] : dwell_q[r] + CNT_W'(1);
      phase_count_d = phase_count_d + PC_W'(step_yr[r] && !short_y[r]);
    end
    conflict      = (nonred & (nonred - 4'd1)) != 4'd0 ? nonred : 4'd0;
    win_code      = |bad ? 3'd1 : |conflict ? 3'd2 : |illegal ? 3'd3 : |short_y ? 3'd4 : |overrun ? 3'd5 : 3'd0;
    win_road      = |bad ? bad : |conflict ? conflict : |illegal ? illegal : |short_y ? short_y : overrun;
    latch         = win_code != 3'd0 && (!fault_q || clr_fault);
    fault_d       = latch ? 1'b1 : clr_fault ? 1'b0 : fault_q;
    fault_code_d  = latch ? win_code : clr_fault ? 3'd0 : fault_code_q;
    fault_road_d  = latch ? win_road : clr_fault ? 4'd0 : fault_road_q;
    active_road_d = nonred;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        prev_col_q[r] <= RED;
        dwell_q[r]    <= '0;
      end
      fault_q       <= 1'b0;
      fault_code_q  <= '0;
      fault_road_q  <= '0;
      active_road_q <= '0;
      phase_count_q <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        prev_col_q[r] <= prev_col_d[r];
        dwell_q[r]    <= dwell_d[r];
      end
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      fault_road_q  <= fault_road_d;
      active_road_q <= active_road_d;
      phase_count_q <= phase_count_d;
    end
  end
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign fault_road  = fault_road_q;
  assign active_road = active_road_q;
  assign phase_count = phase_count_q;
endmodule
